// File: rtl/lead_window_ctrl_pkg.sv
// Shared definitions for the leading-one window sequencer: FSM encoding and
// window geometry derived from the operand width.
package lead_window_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SCAN = 3'd2,
        S_MULT = 3'd3,
        S_WAIT = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam int SIZE_DEF        = 16;
    localparam int ADDRESSSIZE_DEF = 4;
    localparam int WIN             = SIZE_DEF / 2;
    localparam int FLOOR           = WIN - 1;

    function automatic int win_of(input int size);
        return size / 2;
    endfunction

    // Lowest address the scan may settle on; below it the window would fall off the operand.
    function automatic int floor_of(input int size);
        return win_of(size) - 1;
    endfunction

endpackage

// File: rtl/lead_window_ctrl_scan.sv
// Per-operand leading-one search: address down-counter that stops on a set bit,
// on a previous lock, or at the window floor.
module lead_scan
    import lead_window_ctrl_pkg::*;
#(
    parameter int SIZE        = SIZE_DEF,
    parameter int ADDRESSSIZE = ADDRESSSIZE_DEF,
    parameter int FLOOR_ADDR  = floor_of(SIZE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   bit_in,
    output logic [ADDRESSSIZE-1:0] addr,
    output logic                   found
);

    localparam logic [ADDRESSSIZE-1:0] TOP_ADDR = ADDRESSSIZE'(SIZE - 1);
    localparam logic [ADDRESSSIZE-1:0] FLR_ADDR = ADDRESSSIZE'(FLOOR_ADDR);

    logic [ADDRESSSIZE-1:0] r_addr;
    logic                   r_lock;
    logic                   w_found;

    // Floor test sits ahead of the decrement, so the counter can never undershoot.
    assign w_found = r_lock | bit_in | (r_addr == FLR_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= TOP_ADDR;
            r_lock <= 1'b0;
        end else if (clear) begin
            r_addr <= TOP_ADDR;
            r_lock <= 1'b0;
        end else if (enable) begin
            if (w_found) begin
                r_lock <= 1'b1;
            end else begin
                r_addr <= r_addr - 1'b1;
            end
        end
    end

    assign addr  = r_addr;
    assign found = w_found;

endmodule

// File: rtl/lead_window_ctrl.sv
// Sequencer for the two operand window registers: load, leading-one scan per
// operand, multiplier launch/wait, and export of locked addresses and shifts.
module lead_window_ctrl
    import lead_window_ctrl_pkg::*;
#(
    parameter int SIZE        = SIZE_DEF,
    parameter int ADDRESSSIZE = ADDRESSSIZE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   bit_a,
    input  logic                   bit_b,
    input  logic                   mult_done,
    output logic                   load,
    output logic [ADDRESSSIZE-1:0] addr_a,
    output logic [ADDRESSSIZE-1:0] addr_b,
    output logic [ADDRESSSIZE-1:0] shift_a,
    output logic [ADDRESSSIZE-1:0] shift_b,
    output logic                   mult_go,
    output logic                   busy,
    output logic                   done
);

    localparam int                     FLOOR_ADDR = floor_of(SIZE);
    localparam logic [ADDRESSSIZE-1:0] TOP_ADDR   = ADDRESSSIZE'(SIZE - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   w_clear;
    logic                   w_scan_en;
    logic                   w_found_a;
    logic                   w_found_b;
    logic                   w_both;
    logic [ADDRESSSIZE-1:0] r_shift_a;
    logic [ADDRESSSIZE-1:0] r_shift_b;

    // Addresses are re-armed on the IDLE->LOAD edge so they read SIZE-1 during LOAD
    // while the previous result stays visible throughout IDLE.
    assign w_clear   = (r_state == S_IDLE) && start;
    assign w_scan_en = (r_state == S_SCAN);
    assign w_both    = w_found_a & w_found_b;

    lead_scan #(
        .SIZE        (SIZE),
        .ADDRESSSIZE (ADDRESSSIZE),
        .FLOOR_ADDR  (FLOOR_ADDR)
    ) u_scan_a (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .enable (w_scan_en),
        .bit_in (bit_a),
        .addr   (addr_a),
        .found  (w_found_a)
    );

    lead_scan #(
        .SIZE        (SIZE),
        .ADDRESSSIZE (ADDRESSSIZE),
        .FLOOR_ADDR  (FLOOR_ADDR)
    ) u_scan_b (
        .clk    (clk),
        .rst    (rst),
        .clear  (w_clear),
        .enable (w_scan_en),
        .bit_in (bit_b),
        .addr   (addr_b),
        .found  (w_found_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_LOAD;
            S_LOAD:  w_state_next = S_SCAN;
            S_SCAN:  if (w_both) w_state_next = S_MULT;
            S_MULT:  w_state_next = S_WAIT;
            S_WAIT:  if (mult_done) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Shifts are captured on the SCAN->MULT edge from the final (held) addresses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift_a <= '0;
            r_shift_b <= '0;
        end else if (w_scan_en && w_both) begin
            r_shift_a <= TOP_ADDR - addr_a;
            r_shift_b <= TOP_ADDR - addr_b;
        end
    end

    always_comb begin
        load    = 1'b0;
        mult_go = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (r_state)
            S_IDLE:  busy    = 1'b0;
            S_LOAD:  load    = 1'b1;
            S_MULT:  mult_go = 1'b1;
            S_DONE:  done    = 1'b1;
            default: ;
        endcase
    end

    assign shift_a = r_shift_a;
    assign shift_b = r_shift_b;

endmodule

// File: tb/tb_lead_window_ctrl.sv
// Directed and randomized bench for lead_window_ctrl against a leading-one
// reference model of the operands.
module tb_lead_window_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        bit_a;
    logic        bit_b;
    logic        mult_done;
    logic        load;
    logic [3:0]  addr_a;
    logic [3:0]  addr_b;
    logic [3:0]  shift_a;
    logic [3:0]  shift_b;
    logic        mult_go;
    logic        busy;
    logic        done;
    logic [15:0] opa;
    logic [15:0] opb;
    int          n_cmp;
    int          n_err;

    always #5 clk = ~clk;

    // Stand-in for the two window registers: sign output is data[address].
    assign bit_a = opa[addr_a];
    assign bit_b = opb[addr_b];

    lead_window_ctrl #(.SIZE(16), .ADDRESSSIZE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bit_a     (bit_a),
        .bit_b     (bit_b),
        .mult_done (mult_done),
        .load      (load),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .shift_a   (shift_a),
        .shift_b   (shift_b),
        .mult_go   (mult_go),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Where the window settles: highest set bit in the upper half, else the floor (7).
    function automatic int exp_lock(input logic [15:0] v);
        for (int i = 15; i >= 8; i--) begin
            if (v[i]) return i;
        end
        return 7;
    endfunction

    function automatic int imax(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    function automatic logic [15:0] rand_op();
        int          p;
        logic [31:0] v;
        p = $urandom_range(0, 16);
        if (p == 16) return 16'h0000;
        v = (32'd1 << p) | ($urandom & ((32'd1 << p) - 32'd1));
        return v[15:0];
    endfunction

    // One full operation from start to the IDLE cycle after done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit noise, input bit hold, input int wait_cyc);
        int la;
        int lb;
        int n;
        int cyc;
        bit got;
        opa = a;
        opb = b;
        la  = exp_lock(a);
        lb  = exp_lock(b);
        n   = imax(16 - la, 16 - lb);
        start = 1'b1;
        tick();
        chk("load_strobe", load, 1);
        chk("load_busy", busy, 1);
        chk("load_addr_a", addr_a, 15);
        chk("load_addr_b", addr_b, 15);
        if (!hold) start = 1'b0;
        cyc = 1;
        got = 1'b0;
        while (!got && cyc < 40) begin
            if (noise && !hold) begin
                start     = 1'($urandom_range(0, 1));
                mult_done = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
            if (mult_go) begin
                got = 1'b1;
            end else begin
                chk("scan_addr_a", addr_a, imax(15 - (cyc - 2), la));
                chk("scan_addr_b", addr_b, imax(15 - (cyc - 2), lb));
                chk("scan_busy", busy, 1);
            end
        end
        chk("mult_go_seen", mult_go, 1);
        chk("mult_go_cycle", cyc, n + 2);
        chk("mult_addr_a", addr_a, la);
        chk("mult_addr_b", addr_b, lb);
        chk("mult_shift_a", shift_a, 15 - la);
        chk("mult_shift_b", shift_b, 15 - lb);
        start     = hold;
        mult_done = 1'b0;
        tick();
        for (int w = 0; w < wait_cyc; w++) begin
            chk("wait_done", done, 0);
            chk("wait_busy", busy, 1);
            chk("wait_mult_go", mult_go, 0);
            if (noise && !hold) start = 1'b1;
            tick();
        end
        start     = hold;
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("done_pulse", done, 1);
        tick();
        chk("done_width", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_load", load, 0);
        chk("idle_addr_a", addr_a, la);
        chk("idle_addr_b", addr_b, lb);
        chk("idle_shift_a", shift_a, 15 - la);
        chk("idle_shift_b", shift_b, 15 - lb);
    endtask

    initial begin
        bit seen_go;
        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        start     = 1'b0;
        mult_done = 1'b0;
        opa       = 16'h0000;
        opb       = 16'h0000;
        #12;
        chk("rst_addr_a", addr_a, 15);
        chk("rst_addr_b", addr_b, 15);
        chk("rst_shift_a", shift_a, 0);
        chk("rst_shift_b", shift_b, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load", load, 0);
        chk("rst_mult_go", mult_go, 0);
        chk("rst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();

        run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 0);
        run_op(16'h0100, 16'h4000, 1'b0, 1'b0, 2);
        run_op(16'h0005, 16'h0000, 1'b0, 1'b0, 1);
        run_op(16'h0100, 16'h4000, 1'b1, 1'b0, 3);

        // Back-to-back with start held: next LOAD two cycles after done.
        run_op(16'h0100, 16'h4000, 1'b0, 1'b1, 1);
        opa = 16'h8000;
        opb = 16'h0005;
        tick();
        chk("b2b_load", load, 1);
        chk("b2b_addr_a", addr_a, 15);
        chk("b2b_addr_b", addr_b, 15);
        start   = 1'b0;
        seen_go = 1'b0;
        for (int c = 0; c < 20 && !seen_go; c++) begin
            tick();
            if (mult_go) seen_go = 1'b1;
        end
        chk("b2b_mult_go", mult_go, 1);
        chk("b2b_lock_a", addr_a, 15);
        chk("b2b_lock_b", addr_b, 7);
        chk("b2b_shift_a", shift_a, 0);
        chk("b2b_shift_b", shift_b, 8);
        tick();
        mult_done = 1'b1;
        tick();
        mult_done = 1'b0;
        chk("b2b_done", done, 1);
        tick();

        // Asynchronous abort in the middle of a scan.
        opa   = 16'h0005;
        opb   = 16'h0000;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort_pre_addr", addr_a, 13);
        #2 rst = 1'b1;
        #1;
        chk("abort_addr_a", addr_a, 15);
        chk("abort_addr_b", addr_b, 15);
        chk("abort_shift_a", shift_a, 0);
        chk("abort_shift_b", shift_b, 0);
        chk("abort_busy", busy, 0);
        chk("abort_load", load, 0);
        chk("abort_mult_go", mult_go, 0);
        chk("abort_done", done, 0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("post_abort_mult_go", mult_go, 0);
            chk("post_abort_busy", busy, 0);
        end

        for (int r = 0; r < 24; r++) begin
            run_op(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
